// File: rtl/minigpu_pkg.sv
// rtl/minigpu_pkg.sv - shared state encodings and width constants for the dispatcher
package minigpu_pkg;

    localparam int TC_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/free_core_picker.sv
// rtl/free_core_picker.sv - lowest-index free-core priority encoder
//
// Ports:
//   busy  : per-core busy flags
//   found : at least one core is free
//   index : index of the lowest-numbered free core (0 when none)
module free_core_picker #(
    parameter int NUM_CORES = 2,
    parameter int IDX_W     = 1
) (
    input  logic [NUM_CORES-1:0] busy,
    output logic                 found,
    output logic [IDX_W-1:0]     index
);

    // Scan from the top down so the last hit, the lowest index, wins.
    always_comb begin
        found = 1'b0;
        index = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                found = 1'b1;
                index = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/dispatcher.sv
// rtl/dispatcher.sv - block dispatcher handing kernel thread blocks to compute cores
//
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   start              : launch request, honoured in IDLE or DONE
//   thread_count       : total kernel threads, latched on launch
//   core_done          : per-core completion level
//   core_start         : per-core one-cycle assignment pulse
//   core_block_id      : per-core block index, 8 bits per core
//   core_thread_count  : per-core active thread count, CTW bits per core
//   done               : kernel complete
module dispatcher
    import minigpu_pkg::*;
#(
    parameter int NUM_CORES         = 2,
    parameter int THREADS_PER_BLOCK = 4,
    localparam int CTW              = $clog2(THREADS_PER_BLOCK) + 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [TC_W-1:0]          thread_count,
    input  logic [NUM_CORES-1:0]     core_done,
    output logic [NUM_CORES-1:0]     core_start,
    output logic [NUM_CORES*8-1:0]   core_block_id,
    output logic [NUM_CORES*CTW-1:0] core_thread_count,
    output logic                     done
);

    localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int LOG2  = $clog2(THREADS_PER_BLOCK);

    state_t                state;
    logic [TC_W-1:0]       tc_q;
    logic [7:0]            total_blocks;
    logic [7:0]            dispatched;
    logic [7:0]            completed;
    logic [NUM_CORES-1:0]  busy;

    logic                  pick_found;
    logic [IDX_W-1:0]      pick_idx;
    logic [NUM_CORES-1:0]  cmask;
    logic [NUM_CORES-1:0]  set_mask;
    logic [7:0]            ccount;
    logic [8:0]            tc_round;
    logic [7:0]            blocks_calc;
    logic [11:0]           base;
    logic [11:0]           rem;
    logic [CTW-1:0]        blk_cnt;

    free_core_picker #(
        .NUM_CORES (NUM_CORES),
        .IDX_W     (IDX_W)
    ) u_picker (
        .busy  (busy),
        .found (pick_found),
        .index (pick_idx)
    );

    always_comb begin
        // ceil(thread_count / TPB) without overflowing the 8-bit input.
        tc_round    = {1'b0, thread_count} + 9'(THREADS_PER_BLOCK - 1);
        blocks_calc = 8'(tc_round >> LOG2);

        // Completions only count for cores that actually hold a block.
        cmask  = core_done & busy;
        ccount = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            ccount = ccount + 8'(cmask[i]);
        end

        // Picker sees pre-edge busy, so a core finishing this cycle is not reused yet.
        set_mask = '0;
        if (state == ST_RUN && pick_found && dispatched < total_blocks) begin
            set_mask = NUM_CORES'(1) << pick_idx;
        end

        // Only the final block can be short.
        base = 12'(dispatched) * 12'(THREADS_PER_BLOCK);
        rem  = 12'(tc_q) - base;
        if (rem >= 12'(THREADS_PER_BLOCK)) begin
            blk_cnt = CTW'(THREADS_PER_BLOCK);
        end else begin
            blk_cnt = rem[CTW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= ST_IDLE;
            tc_q              <= '0;
            total_blocks      <= '0;
            dispatched        <= '0;
            completed         <= '0;
            busy              <= '0;
            core_start        <= '0;
            core_block_id     <= '0;
            core_thread_count <= '0;
            done              <= 1'b0;
        end else begin
            core_start <= set_mask;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        tc_q         <= thread_count;
                        total_blocks <= blocks_calc;
                        dispatched   <= '0;
                        completed    <= '0;
                        busy         <= '0;
                        if (thread_count == '0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_RUN;
                            done  <= 1'b0;
                        end
                    end
                end
                ST_RUN: begin
                    if (completed == total_blocks) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end else begin
                        busy      <= (busy & ~cmask) | set_mask;
                        completed <= completed + ccount;
                        if (set_mask != '0) begin
                            dispatched <= dispatched + 8'd1;
                        end
                        for (int i = 0; i < NUM_CORES; i++) begin
                            if (set_mask[i]) begin
                                core_block_id[8*i +: 8]         <= dispatched;
                                core_thread_count[CTW*i +: CTW] <= blk_cnt;
                            end
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
